// File: rtl/register_file_mp_if.sv
// Bus bundle for the multi-ported register file: two read ports, two write ports, reserve request.
// The core side uses the master modport and the register file uses the slave modport.
interface register_file_mp_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 5
);
  logic [ADDR_W-1:0] a1;
  logic [ADDR_W-1:0] a2;
  logic [XLEN-1:0]   rd1;
  logic [XLEN-1:0]   rd2;
  logic              busy1;
  logic              busy2;

  logic [ADDR_W-1:0] a3;
  logic [XLEN-1:0]   di3;
  logic              we3;
  logic [ADDR_W-1:0] a4;
  logic [XLEN-1:0]   di4;
  logic              we4;

  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;

  modport master (
    output a1, a2, a3, di3, we3, a4, di4, we4, rsv_en, rsv_addr,
    input  rd1, rd2, busy1, busy2
  );

  modport slave (
    input  a1, a2, a3, di3, we3, a4, di4, we4, rsv_en, rsv_addr,
    output rd1, rd2, busy1, busy2
  );
endinterface

// File: rtl/register_file_mp.sv
// Register file with 2 async read ports, 2 sync write ports (port 4 wins), optional zero register,
// optional write-to-read bypass and a per-register busy scoreboard for hazard detection.
module register_file_mp #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input logic               clk,
  input logic               reset_n,
  register_file_mp_if.slave bus
);
  localparam int unsigned NREGS = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [XLEN-1:0]   data_t;

  data_t            regs_q [NREGS];
  data_t            regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  logic wr3_ok;
  logic wr4_ok;
  logic rsv_ok;
  logic bypass_en;

  addr_t ra      [2];
  data_t rdata   [2];
  logic  rbusy   [2];
  logic  hit3    [2];
  logic  hit4    [2];
  logic  zero_rd [2];

  function automatic logic is_zero(addr_t a);
    return ZERO_REG && (a == '0);
  endfunction

  // Enables are evaluated before the address is used, so a junk address with enable low is inert.
  assign wr3_ok    = bus.we3 && !is_zero(bus.a3);
  assign wr4_ok    = bus.we4 && !is_zero(bus.a4);
  assign rsv_ok    = bus.rsv_en && !is_zero(bus.rsv_addr);
  assign bypass_en = BYPASS && reset_n;

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr3_ok) begin
      regs_d[bus.a3] = bus.di3;
      busy_d[bus.a3] = 1'b0;
    end
    if (wr4_ok) begin
      regs_d[bus.a4] = bus.di4;
      busy_d[bus.a4] = 1'b0;
    end
    // A reservation landing on the same edge as a write keeps the register busy.
    if (rsv_ok) begin
      busy_d[bus.rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign ra[0] = bus.a1;
  assign ra[1] = bus.a2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      zero_rd[p] = is_zero(ra[p]);
      hit3[p]    = bypass_en && bus.we3 && (bus.a3 == ra[p]);
      hit4[p]    = bypass_en && bus.we4 && (bus.a4 == ra[p]);
      if (zero_rd[p]) begin
        rdata[p] = '0;
      end else if (hit4[p]) begin
        rdata[p] = bus.di4;
      end else if (hit3[p]) begin
        rdata[p] = bus.di3;
      end else begin
        rdata[p] = regs_q[ra[p]];
      end
      rbusy[p] = busy_q[ra[p]] && !hit3[p] && !hit4[p] && !zero_rd[p];
    end
  end

  assign bus.rd1   = rdata[0];
  assign bus.rd2   = rdata[1];
  assign bus.busy1 = rbusy[0];
  assign bus.busy2 = rbusy[1];

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: a default instance and a no-zero-reg/no-bypass instance share stimulus
// and are checked against an array-based reference model after directed and random steps.
module tb_register_file_mp;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NREGS  = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] a1, a2, a3, a4, rsv_addr;
  logic [XLEN-1:0]   di3, di4;
  logic              we3, we4, rsv_en;

  int n_tests = 0;
  int n_fail  = 0;

  logic [XLEN-1:0] m_mem  [2][NREGS];
  logic            m_busy [2][NREGS];
  bit              m_zr   [2] = '{1'b1, 1'b0};
  bit              m_bp   [2] = '{1'b1, 1'b0};

  always #5 clk = ~clk;

  register_file_mp_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus0 ();
  register_file_mp_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus1 ();

  assign bus0.a1 = a1;   assign bus1.a1 = a1;
  assign bus0.a2 = a2;   assign bus1.a2 = a2;
  assign bus0.a3 = a3;   assign bus1.a3 = a3;
  assign bus0.a4 = a4;   assign bus1.a4 = a4;
  assign bus0.di3 = di3; assign bus1.di3 = di3;
  assign bus0.di4 = di4; assign bus1.di4 = di4;
  assign bus0.we3 = we3; assign bus1.we3 = we3;
  assign bus0.we4 = we4; assign bus1.we4 = we4;
  assign bus0.rsv_en = rsv_en;     assign bus1.rsv_en = rsv_en;
  assign bus0.rsv_addr = rsv_addr; assign bus1.rsv_addr = rsv_addr;

  register_file_mp #(.XLEN(XLEN), .ADDR_W(ADDR_W), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  register_file_mp #(.XLEN(XLEN), .ADDR_W(ADDR_W), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_rd(input int k, input logic [ADDR_W-1:0] a);
    if (m_zr[k] && a == 0) return '0;
    if (m_bp[k] && reset_n && we4 && a4 == a) return di4;
    if (m_bp[k] && reset_n && we3 && a3 == a) return di3;
    return m_mem[k][a];
  endfunction

  function automatic logic exp_busy(input int k, input logic [ADDR_W-1:0] a);
    logic hit;
    if (m_zr[k] && a == 0) return 1'b0;
    hit = m_bp[k] && reset_n && ((we3 && a3 == a) || (we4 && a4 == a));
    return m_busy[k][a] && !hit;
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        for (int i = 0; i < int'(NREGS); i++) begin
          m_mem[k][i]  = '0;
          m_busy[k][i] = 1'b0;
        end
      end else begin
        if (we3 && !(m_zr[k] && a3 == 0)) begin
          m_mem[k][a3] = di3;
          m_busy[k][a3] = 1'b0;
        end
        if (we4 && !(m_zr[k] && a4 == 0)) begin
          m_mem[k][a4] = di4;
          m_busy[k][a4] = 1'b0;
        end
        if (rsv_en && !(m_zr[k] && rsv_addr == 0)) m_busy[k][rsv_addr] = 1'b1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".rd1_z"}, bus0.rd1, exp_rd(0, a1));
    check({tag, ".rd2_z"}, bus0.rd2, exp_rd(0, a2));
    check({tag, ".busy1_z"}, {31'b0, bus0.busy1}, {31'b0, exp_busy(0, a1)});
    check({tag, ".busy2_z"}, {31'b0, bus0.busy2}, {31'b0, exp_busy(0, a2)});
    check({tag, ".rd1_p"}, bus1.rd1, exp_rd(1, a1));
    check({tag, ".rd2_p"}, bus1.rd2, exp_rd(1, a2));
    check({tag, ".busy1_p"}, {31'b0, bus1.busy1}, {31'b0, exp_busy(1, a1)});
    check({tag, ".busy2_p"}, {31'b0, bus1.busy2}, {31'b0, exp_busy(1, a2)});
  endtask

  // Check combinational outputs mid-cycle, then take one edge and advance the model.
  task automatic step(input string tag);
    #1;
    check_model(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    we3 = 1'b0; we4 = 1'b0; rsv_en = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    a1 = '0; a2 = '0; a3 = 5'd3; a4 = 5'd4; rsv_addr = 5'd6;
    di3 = 32'hDEAD_BEEF; di4 = 32'hCAFE_F00D;
    we3 = 1'b1; we4 = 1'b1; rsv_en = 1'b1;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < int'(NREGS); i++) begin
        m_mem[k][i] = '0; m_busy[k][i] = 1'b0;
      end

    // Reset edge: storage is unknown beforehand, so nothing is checked until it has been taken.
    @(posedge clk);
    model_edge();
    #1;
    reset_n = 1'b1;
    idle();
    for (int i = 0; i < int'(NREGS); i++) begin
      a1 = 5'(i);
      #1;
      check("rst.rd1_z", bus0.rd1, '0);
      check("rst.busy1_z", {31'b0, bus0.busy1}, '0);
      check("rst.rd1_p", bus1.rd1, '0);
      check("rst.busy1_p", {31'b0, bus1.busy1}, '0);
    end

    // Write/read with and without bypass.
    a1 = 5'd1; a2 = 5'd1; we3 = 1'b1; a3 = 5'd1; di3 = 32'd69;
    #1;
    check("wr.bypass", bus0.rd1, 32'd69);
    check("wr.nobypass", bus1.rd1, 32'd0);
    step("wr");
    idle();
    #1;
    check("wr.after_z", bus0.rd1, 32'd69);
    check("wr.after_p", bus1.rd1, 32'd69);

    // Both write ports on one address: port 4 wins.
    we3 = 1'b1; we4 = 1'b1; a3 = 5'd5; a4 = 5'd5; di3 = 32'h11; di4 = 32'h22; a1 = 5'd5;
    #1;
    check("conf.during", bus0.rd1, 32'h22);
    step("conf");
    idle();
    #1;
    check("conf.after_z", bus0.rd1, 32'h22);
    check("conf.after_p", bus1.rd1, 32'h22);

    // Zero register: write and reserve to address 0.
    we3 = 1'b1; a3 = 5'd0; di3 = 32'hFFFF_FFFF; rsv_en = 1'b1; rsv_addr = 5'd0; a1 = 5'd0;
    step("zero");
    idle();
    #1;
    check("zero.rd_z", bus0.rd1, 32'd0);
    check("zero.busy_z", {31'b0, bus0.busy1}, 32'd0);
    check("zero.rd_p", bus1.rd1, 32'hFFFF_FFFF);
    check("zero.busy_p", {31'b0, bus1.busy1}, 32'd1);

    // Scoreboard reserve, clear by write, and reserve-beats-write.
    rsv_en = 1'b1; rsv_addr = 5'd7; a2 = 5'd7;
    #1;
    check("sb.not_yet", {31'b0, bus0.busy2}, 32'd0);
    step("sb.rsv");
    idle();
    #1;
    check("sb.busy_z", {31'b0, bus0.busy2}, 32'd1);
    we4 = 1'b1; a4 = 5'd7; di4 = 32'h77;
    #1;
    check("sb.clr_bypass_z", {31'b0, bus0.busy2}, 32'd0);
    check("sb.clr_nobypass_p", {31'b0, bus1.busy2}, 32'd1);
    step("sb.clr");
    idle();
    #1;
    check("sb.cleared_z", {31'b0, bus0.busy2}, 32'd0);
    check("sb.cleared_p", {31'b0, bus1.busy2}, 32'd0);
    rsv_en = 1'b1; rsv_addr = 5'd7; we3 = 1'b1; a3 = 5'd7; di3 = 32'h99;
    step("sb.both");
    idle();
    #1;
    check("sb.both_busy_z", {31'b0, bus0.busy2}, 32'd1);
    check("sb.both_busy_p", {31'b0, bus1.busy2}, 32'd1);
    check("sb.both_data_z", bus0.rd2, 32'h99);
    check("sb.both_data_p", bus1.rd2, 32'h99);

    // Reset in the middle of operation, with a write pending on the reset edge.
    we3 = 1'b1; a3 = 5'd3; di3 = 32'hA5;
    step("mid.wr");
    idle();
    rsv_en = 1'b1; rsv_addr = 5'd3; a1 = 5'd3;
    step("mid.rsv");
    idle();
    #1;
    check("mid.busy_pre", {31'b0, bus0.busy1}, 32'd1);
    check("mid.rd_pre", bus0.rd1, 32'hA5);
    reset_n = 1'b0; we3 = 1'b1; a3 = 5'd3; di3 = 32'h5A;
    #1;
    check("mid.no_bypass_in_rst", bus0.rd1, 32'hA5);
    step("mid.rst");
    reset_n = 1'b1;
    idle();
    #1;
    check("mid.rd_z", bus0.rd1, 32'd0);
    check("mid.busy_z", {31'b0, bus0.busy1}, 32'd0);
    check("mid.rd_p", bus1.rd1, 32'd0);
    check("mid.busy_p", {31'b0, bus1.busy1}, 32'd0);

    // Random traffic; a narrow address range on some steps forces collisions and bypass hits.
    for (int n = 0; n < 400; n++) begin
      automatic int unsigned hi = ($urandom_range(0, 1) == 0) ? 3 : 31;
      reset_n  = ($urandom_range(0, 39) != 0);
      a1       = 5'($urandom_range(0, hi));
      a2       = 5'($urandom_range(0, hi));
      a3       = 5'($urandom_range(0, hi));
      a4       = 5'($urandom_range(0, hi));
      rsv_addr = 5'($urandom_range(0, hi));
      di3      = $urandom;
      di4      = $urandom;
      we3      = 1'($urandom_range(0, 1));
      we4      = 1'($urandom_range(0, 1));
      rsv_en   = 1'($urandom_range(0, 1));
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
